// File: rtl/weights_fetcher.sv
// Streams NUM_WORDS memory words as signed R/G/B weight triples over valid/ready.
// A 2-entry buffer plus one in-flight read lets backpressure stall fetching without losing data.
module weights_fetcher #(
  parameter int DATA_WIDTH = 5,
  parameter int Addr_Depth = 12,
  parameter int NUM_WORDS  = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [Addr_Depth-1:0]         mem_address,
  output logic                          mem_en_read,
  input  logic [3*DATA_WIDTH-1:0]       mem_data_in,
  output logic                          w_valid,
  input  logic                          w_ready,
  output logic signed [DATA_WIDTH-1:0]  w_r,
  output logic signed [DATA_WIDTH-1:0]  w_g,
  output logic signed [DATA_WIDTH-1:0]  w_b,
  output logic [Addr_Depth-1:0]         w_index
);

  localparam int WW = 3 * DATA_WIDTH;
  localparam logic [Addr_Depth-1:0] LAST_ADDR = Addr_Depth'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WW-1:0]         r_buf_data [2];
  logic [Addr_Depth-1:0] r_buf_idx  [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_in_flight;
  logic [Addr_Depth-1:0] r_flight_idx;
  logic [Addr_Depth-1:0] r_addr;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_tail;
  logic [2:0]            w_occ;

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign w_pop   = (r_count != 2'd0) && w_ready;
  assign w_push  = r_in_flight;
  assign w_occ   = {1'b0, r_count} + {2'b0, r_in_flight} - {2'b0, w_pop};
  assign w_issue = (r_state == S_FETCH) && !abort && (w_occ < 3'd2);
  assign w_tail  = r_head ^ r_count[0];

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_next = S_FETCH;
        S_FETCH: if (w_issue && (r_addr == LAST_ADDR)) w_state_next = S_DRAIN;
        S_DRAIN: if (w_occ == 3'd0) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_in_flight  <= 1'b0;
      r_flight_idx <= '0;
      r_addr       <= '0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_idx[i]  <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (abort) begin
        r_head      <= 1'b0;
        r_count     <= 2'd0;
        r_in_flight <= 1'b0;
        r_addr      <= '0;
      end else begin
        r_in_flight <= w_issue;
        // The last address is held rather than wrapped; DONE rewinds it.
        if (w_issue) begin
          r_flight_idx <= r_addr;
          if (r_addr != LAST_ADDR) r_addr <= r_addr + Addr_Depth'(1);
        end else if (r_state == S_DONE) begin
          r_addr <= '0;
        end
        if (w_push) begin
          r_buf_data[w_tail] <= mem_data_in;
          r_buf_idx[w_tail]  <= r_flight_idx;
        end
        if (w_pop) r_head <= ~r_head;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_address = r_addr;
  assign mem_en_read = w_issue;
  assign w_valid     = (r_count != 2'd0);
  assign w_r         = r_buf_data[r_head][WW-1:2*DATA_WIDTH];
  assign w_g         = r_buf_data[r_head][2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_b         = r_buf_data[r_head][DATA_WIDTH-1:0];
  assign w_index     = r_buf_idx[r_head];

endmodule

// File: tb/tb_weights_fetcher.sv
// Bench for weights_fetcher: registered memory model, beat scoreboard and cycle-exact
// checks of start/abort/reset/backpressure behaviour on an 8-word run.
module tb_weights_fetcher;

  localparam int DW = 5;
  localparam int AD = 12;
  localparam int NW = 8;

  logic                 clock = 1'b0;
  logic                 reset, start, abort, w_ready;
  logic                 busy, done, mem_en_read, w_valid;
  logic [AD-1:0]        mem_address, w_index;
  logic [3*DW-1:0]      mem_data_in;
  logic signed [DW-1:0] w_r, w_g, w_b;

  weights_fetcher #(.DATA_WIDTH(DW), .Addr_Depth(AD), .NUM_WORDS(NW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_en_read(mem_en_read),
    .mem_data_in(mem_data_in), .w_valid(w_valid), .w_ready(w_ready),
    .w_r(w_r), .w_g(w_g), .w_b(w_b), .w_index(w_index)
  );

  always #5 clock = ~clock;

  // Memory returns the word one cycle after en_read; otherwise a junk value stands in for Z.
  logic [3*DW-1:0] mem [0:NW-1];
  logic [3*DW-1:0] rd_data;
  logic            rd_valid;
  always @(posedge clock) begin
    rd_valid <= mem_en_read;
    rd_data  <= mem[mem_address[2:0]];
  end
  assign mem_data_in = rd_valid ? rd_data : 15'h2B5A;

  typedef struct {
    logic [AD-1:0]        idx;
    logic signed [DW-1:0] r, g, b;
  } exp_t;

  typedef struct {
    logic [3*DW-1:0]      word;
    logic signed [DW-1:0] r, g, b;
  } vec_t;

  vec_t    tbl [NW];
  exp_t    cur_exp [NW];
  exp_t    sb [$];

  int      checks = 0, errors = 0, gcyc = 0;
  int      n_done, n_beats, n_en, last_pop, done_cyc;
  logic [AD-1:0] exp_addr;
  logic    s_en, s_valid, s_busy, s_done;
  logic [AD-1:0] s_index;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  // One clock cycle: sample at negedge, score reads and beats, then advance.
  task automatic step();
    exp_t e;
    @(negedge clock);
    s_en = mem_en_read; s_valid = w_valid; s_busy = busy; s_done = done; s_index = w_index;
    if (mem_en_read) begin
      chk("read_addr", 32'(mem_address), 32'(exp_addr));
      exp_addr++;
      n_en++;
    end
    if (w_valid && w_ready) begin
      n_beats++;
      last_pop = gcyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got index %0d expected no beat (cycle %0d)", w_index, gcyc);
      end else begin
        e = sb.pop_front();
        $display("beat idx=%0d r=%0d g=%0d b=%0d cycle=%0d", w_index, w_r, w_g, w_b, gcyc);
        chk("beat", {5'b0, w_index, w_r, w_g, w_b}, {5'b0, e.idx, e.r, e.g, e.b});
      end
    end
    if (done) begin
      n_done++;
      done_cyc = gcyc;
    end
    @(posedge clock);
    #1;
    gcyc++;
  endtask

  task automatic chk_quiet_outputs(input string tag);
    @(negedge clock);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_en"},    32'(mem_en_read), 0);
    chk({tag, "_valid"}, 32'(w_valid), 0);
    chk({tag, "_addr"},  32'(mem_address), 0);
    chk({tag, "_wr"},    32'(w_r), 0);
    chk({tag, "_wg"},    32'(w_g), 0);
    chk({tag, "_wb"},    32'(w_b), 0);
    chk({tag, "_idx"},   32'(w_index), 0);
    @(posedge clock);
    #1;
    gcyc++;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NW; i++) begin
      mem[i]     = {5'(i), 5'(-i), 5'(i)};
      cur_exp[i] = '{idx: AD'(i), r: 5'(i), g: 5'(-i), b: 5'(i)};
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NW; i++) begin
      mem[i]     = tbl[i].word;
      cur_exp[i] = '{idx: AD'(i), r: tbl[i].r, g: tbl[i].g, b: tbl[i].b};
    end
  endtask

  task automatic begin_run();
    sb.delete();
    for (int i = 0; i < NW; i++) sb.push_back(cur_exp[i]);
    exp_addr = '0; n_done = 0; n_beats = 0; n_en = 0;
    last_pop = -1; done_cyc = -1; s_done = 1'b0; gcyc = 0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    for (int k = 0; k < budget && !s_done; k++) step();
    chk({tag, "_done_seen"}, 32'(s_done), 1);
    chk({tag, "_beats"}, 32'(n_beats), NW);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    tbl[0] = '{word: 15'h7C1F, r: -5'sd1,  g: 5'sd0,   b: -5'sd1};
    tbl[1] = '{word: 15'h0000, r: 5'sd0,   g: 5'sd0,   b: 5'sd0};
    tbl[2] = '{word: 15'h7FFF, r: -5'sd1,  g: -5'sd1,  b: -5'sd1};
    tbl[3] = '{word: 15'h4210, r: -5'sd16, g: -5'sd16, b: -5'sd16};
    tbl[4] = '{word: 15'h3DEF, r: 5'sd15,  g: 5'sd15,  b: 5'sd15};
    tbl[5] = '{word: 15'h0421, r: 5'sd1,   g: 5'sd1,   b: 5'sd1};
    tbl[6] = '{word: 15'h5555, r: -5'sd11, g: 5'sd10,  b: -5'sd11};
    tbl[7] = '{word: 15'h2AAA, r: 5'sd10,  g: -5'sd11, b: 5'sd10};

    reset = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_quiet_outputs("reset");
    reset = 1'b0;

    // Basic run: exact cycles of en_read, w_valid, busy and done.
    load_ramp();
    begin_run();
    for (int c = 0; c <= 13; c++) begin
      start = (c == 0);
      step();
      chk("t1_en",    32'(s_en),    32'(c >= 1 && c <= 8));
      chk("t1_valid", 32'(s_valid), 32'(c >= 3 && c <= 10));
      chk("t1_busy",  32'(s_busy),  32'(c >= 1 && c <= 11));
      chk("t1_done",  32'(s_done),  32'(c == 11));
    end
    chk("t1_beats", 32'(n_beats), NW);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Sign extremes from the vector table.
    load_table();
    begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("t2", 40);

    // Backpressure in cycles 4-9: reads stall, head entry holds.
    load_ramp();
    begin_run();
    for (int c = 0; c <= 9; c++) begin
      start   = (c == 0);
      w_ready = !(c >= 4 && c <= 9);
      step();
      if (c >= 4) begin
        chk("t3_stall_en",    32'(s_en), 0);
        chk("t3_stall_valid", 32'(s_valid), 1);
        chk("t3_stall_idx",   32'(s_index), 1);
      end
    end
    w_ready = 1'b1;
    run_to_done("t3", 40);
    chk("t3_done_after_pop", 32'(done_cyc), 32'(last_pop + 1));
    chk("t3_reads", 32'(n_en), NW);

    // Abort in cycle 5, then a fresh run from address 0.
    begin_run();
    for (int c = 0; c <= 5; c++) begin
      start = (c == 0);
      abort = (c == 5);
      step();
    end
    abort = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      step();
      chk("t4_busy",  32'(s_busy), 0);
      chk("t4_valid", 32'(s_valid), 0);
      chk("t4_en",    32'(s_en), 0);
    end
    chk("t4_no_done", 32'(n_done), 0);
    begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("t4r", 40);

    // start re-asserted mid-run is ignored.
    begin_run();
    for (int c = 0; c <= 15; c++) begin
      start = (c == 0) || (c >= 3 && c <= 6);
      step();
    end
    chk("t5_beats", 32'(n_beats), NW);
    chk("t5_done",  32'(n_done), 1);
    chk("t5_reads", 32'(n_en), NW);

    // Reset mid-run in cycle 6.
    begin_run();
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      reset = (c == 6);
      step();
    end
    reset = 1'b0;
    chk_quiet_outputs("t6");
    for (int c = 8; c <= 10; c++) step();
    chk("t6_no_done", 32'(n_done), 0);
    begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("t6r", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
